// File: rtl/ctrl_dispatch_queue.sv
// Command front-end: buffers host control packets in a FIFO, decodes them in order and
// dispatches each to one processing unit over valid/ready, tracking per-unit COMP-busy.
module ctrl_dispatch_queue #(
  parameter int NUM_UNITS  = 4,
  parameter int UNIT_ID_W  = 2,
  parameter int ADDR_W     = 4,
  parameter int SIZE_W     = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  localparam int PKT_W     = UNIT_ID_W + 4 + ADDR_W + 1 + SIZE_W,
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid_i,
  input  logic [PKT_W-1:0]     pkt_i,
  output logic                 pkt_ready_o,
  output logic [NUM_UNITS-1:0] disp_valid_o,
  input  logic [NUM_UNITS-1:0] disp_ready_i,
  output logic [1:0]           disp_op_o,
  output logic [1:0]           disp_comp_o,
  output logic [ADDR_W-1:0]    disp_addr_o,
  output logic [SIZE_W-1:0]    disp_size_o,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  output logic [NUM_UNITS-1:0] unit_busy_o,
  output logic [FCNT_W-1:0]    fifo_count_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  // state | meaning
  // IDLE  | decode register empty, waiting for a FIFO entry
  // CHECK | decode register holds a fresh packet, classify it
  // BLOCK | COMP packet held until its unit's busy flag clears
  // ISSUE | disp_valid_o asserted, waiting for the unit's ready
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BLOCK, S_ISSUE} state_t;

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int UNITS_MAX = 1 << UNIT_ID_W;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_COMP = 2'b11;

  state_t state_q, state_d;

  logic [PKT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, push, pop;

  logic [PKT_W-1:0]     pkt_q;
  logic [UNIT_ID_W-1:0] dec_unit;
  logic [1:0]           dec_op, dec_comp;
  logic [ADDR_W-1:0]    dec_addr;
  logic                 dec_valid;
  logic [SIZE_W-1:0]    dec_size;
  logic                 dec_bad_unit, dec_busy;

  logic [UNITS_MAX-1:0] busy_ext;
  logic [NUM_UNITS-1:0] busy_set;
  logic                 handshake, load_disp, clear_disp, drop_inc, err_set;

  // full blocks pushes even when a pop happens in the same cycle
  assign fifo_full   = (fifo_count_o == FCNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_count_o == '0);
  assign pkt_ready_o = ~fifo_full;
  assign push        = pkt_valid_i & ~fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pkt_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + FCNT_W'(1);
        2'b01:   fifo_count_o <= fifo_count_o - FCNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pkt_q <= '0;
    else if (pop) pkt_q <= fifo_mem[rd_ptr];
  end

  assign dec_size  = pkt_q[SIZE_W-1:0];
  assign dec_valid = pkt_q[SIZE_W];
  assign dec_addr  = pkt_q[SIZE_W+1 +: ADDR_W];
  assign dec_comp  = pkt_q[SIZE_W+1+ADDR_W +: 2];
  assign dec_op    = pkt_q[SIZE_W+3+ADDR_W +: 2];
  assign dec_unit  = pkt_q[PKT_W-1 -: UNIT_ID_W];

  // widened so an out-of-range unit id never indexes past the busy vector
  assign busy_ext     = UNITS_MAX'(unit_busy_o);
  assign dec_bad_unit = ({1'b0, dec_unit} >= (UNIT_ID_W+1)'(NUM_UNITS));
  assign dec_busy     = (dec_op == OP_COMP) && busy_ext[dec_unit];
  assign handshake    = (state_q == S_ISSUE) && (|(disp_valid_o & disp_ready_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load_disp  = 1'b0;
    clear_disp = 1'b0;
    drop_inc   = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!dec_valid) begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end else if (dec_bad_unit) begin
          drop_inc = 1'b1;
          err_set  = 1'b1;
          state_d  = S_IDLE;
        end else if (dec_op == OP_NOP) begin
          state_d = S_IDLE;
        end else if (dec_busy) begin
          state_d = S_BLOCK;
        end else begin
          load_disp = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_BLOCK: begin
        if (!dec_busy) begin
          load_disp = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          clear_disp = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid_o <= '0;
      disp_op_o    <= '0;
      disp_comp_o  <= '0;
      disp_addr_o  <= '0;
      disp_size_o  <= '0;
    end else if (load_disp) begin
      disp_valid_o <= NUM_UNITS'(1) << dec_unit;
      disp_op_o    <= dec_op;
      disp_comp_o  <= dec_comp;
      disp_addr_o  <= dec_addr;
      disp_size_o  <= dec_size;
    end else if (clear_disp) begin
      disp_valid_o <= '0;
      disp_op_o    <= '0;
      disp_comp_o  <= '0;
      disp_addr_o  <= '0;
      disp_size_o  <= '0;
    end
  end

  // a COMP handshake sets busy and wins over a coincident done
  assign busy_set = (handshake && disp_op_o == OP_COMP) ? disp_valid_o : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unit_busy_o <= '0;
    else        unit_busy_o <= (unit_busy_o & ~unit_done_i) | busy_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

endmodule
